arbitro_round_robin: RTL and testbench

- Round-robin arbiter for the four per-lane input FIFOs that feed the 4:1 data mux.
- Each cycle it picks one non-empty lane and pops it, then drives the mux selector and the output-FIFO push one cycle later, aligned with the popped word.
- It stalls on downstream almost-full and keeps a saturating grant counter per lane.

---
 rtl/arbitro_round_robin.sv | 87 ++++++++
 tb/tb_arbitro_round_robin.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_round_robin.sv
// Round-robin arbiter for four input FIFOs feeding a 4:1 mux. It pops one non-empty lane per cycle
// and issues the matching downstream push and mux select one cycle later.
module arbitro_round_robin #(
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   enb,
  input  logic [3:0]             vacio_in,
  input  logic                   casi_lleno_out,
  output logic [3:0]             pop,
  output logic                   push_out,
  output logic [1:0]             selector_mux,
  output logic [1:0]             estado,
  output logic [COUNT_WIDTH-1:0] cuenta0,
  output logic [COUNT_WIDTH-1:0] cuenta1,
  output logic [COUNT_WIDTH-1:0] cuenta2,
  output logic [COUNT_WIDTH-1:0] cuenta3
);

  typedef enum logic [1:0] {
    StInit   = 2'b00,
    StIdle   = 2'b01,
    StActive = 2'b10
  } state_e;

  state_e                 state_q;
  logic [1:0]             ptr_q;
  logic [COUNT_WIDTH-1:0] cnt_q [4];

  logic       any_ready;
  logic       grant;
  logic       found;
  logic [1:0] cand;
  logic [1:0] gnt_lane;

  assign any_ready = (vacio_in != 4'hF);
  assign grant     = (state_q == StActive) && enb && !casi_lleno_out && any_ready;

  // Search starts just after the last granted lane, so it wraps to itself last.
  always_comb begin
    found    = 1'b0;
    cand     = ptr_q;
    gnt_lane = ptr_q;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && !vacio_in[cand]) begin
        found    = 1'b1;
        gnt_lane = cand;
      end
    end
  end

  // Mealy pop: the FIFO read is registered, so the word reaches the mux next cycle.
  assign pop = grant ? (4'b0001 << gnt_lane) : 4'b0000;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= StInit;
      ptr_q        <= 2'd3;
      push_out     <= 1'b0;
      selector_mux <= 2'd0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      case (state_q)
        StInit:   state_q <= StIdle;
        StIdle:   if (enb && any_ready) state_q <= StActive;
        StActive: if (!enb || !any_ready) state_q <= StIdle;
        default:  state_q <= StInit;
      endcase
      push_out <= grant;
      if (grant) begin
        ptr_q        <= gnt_lane;
        selector_mux <= gnt_lane;
        // Saturate instead of wrapping; the grant itself is never withheld.
        if (cnt_q[gnt_lane] != '1) cnt_q[gnt_lane] <= cnt_q[gnt_lane] + COUNT_WIDTH'(1);
      end
    end
  end

  assign estado  = state_q;
  assign cuenta0 = cnt_q[0];
  assign cuenta1 = cnt_q[1];
  assign cuenta2 = cnt_q[2];
  assign cuenta3 = cnt_q[3];

endmodule

// File: tb/tb_arbitro_round_robin.sv
// Directed self-checking bench for arbitro_round_robin, using a 2-bit grant counter so that
// saturation is reachable in a few grants.
module tb_arbitro_round_robin;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       enb;
  logic [3:0] vacio_in;
  logic       casi_lleno_out;
  logic [3:0] pop;
  logic       push_out;
  logic [1:0] selector_mux;
  logic [1:0] estado;
  logic [1:0] cuenta0, cuenta1, cuenta2, cuenta3;

  int checks = 0;
  int errors = 0;

  arbitro_round_robin #(.COUNT_WIDTH(2)) dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .enb            (enb),
    .vacio_in       (vacio_in),
    .casi_lleno_out (casi_lleno_out),
    .pop            (pop),
    .push_out       (push_out),
    .selector_mux   (selector_mux),
    .estado         (estado),
    .cuenta0        (cuenta0),
    .cuenta1        (cuenta1),
    .cuenta2        (cuenta2),
    .cuenta3        (cuenta3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset_L        = 1'b0;
    vacio_in       = 4'hF;
    enb            = 1'b1;
    casi_lleno_out = 1'b0;
    tick();
    tick();
    reset_L = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_pop;
    logic [1:0] exp_sel;

    // Reset then idle
    reset_L        = 1'b1;
    enb            = 1'b1;
    vacio_in       = 4'hF;
    casi_lleno_out = 1'b0;
    #1 reset_L = 1'b0;
    #1;
    chk("rst_estado", 8'(estado), 8'h0);
    chk("rst_push", 8'(push_out), 8'h0);
    chk("rst_sel", 8'(selector_mux), 8'h0);
    chk("rst_pop", 8'(pop), 8'h0);
    chk("rst_cnt", 8'({cuenta3, cuenta2, cuenta1, cuenta0}), 8'h00);
    tick();
    tick();
    reset_L = 1'b1;
    tick(); #1;
    chk("idle_estado", 8'(estado), 8'h1);
    tick(); #1;
    chk("idle_stay", 8'(estado), 8'h1);
    chk("idle_pop", 8'(pop), 8'h0);
    chk("idle_push", 8'(push_out), 8'h0);

    // Fairness, all lanes busy
    vacio_in = 4'h0;
    #1;
    chk("fair_pop_idle", 8'(pop), 8'h0);
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      exp_pop = 4'b0001 << (i % 4);
      chk("fair_estado", 8'(estado), 8'h2);
      chk("fair_pop", 8'(pop), 8'(exp_pop));
      chk("fair_push", 8'(push_out), (i > 0) ? 8'h1 : 8'h0);
      if (i > 0) begin
        exp_sel = 2'((i - 1) % 4);
        chk("fair_sel", 8'(selector_mux), 8'(exp_sel));
      end
    end
    tick();
    vacio_in = 4'hF;
    #1;
    chk("fair_tail_pop", 8'(pop), 8'h0);
    chk("fair_tail_push", 8'(push_out), 8'h1);
    chk("fair_tail_sel", 8'(selector_mux), 8'h3);
    chk("fair_cnt", 8'({cuenta3, cuenta2, cuenta1, cuenta0}), 8'hAA);
    tick(); #1;
    chk("fair_back_idle", 8'(estado), 8'h1);
    chk("fair_push_off", 8'(push_out), 8'h0);
    chk("fair_sel_hold", 8'(selector_mux), 8'h3);

    // Skipping empty lanes
    do_reset();
    tick();
    vacio_in = 4'b1010;
    #1;
    chk("skip_estado", 8'(estado), 8'h1);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("skip_pop", 8'(pop), (i % 2 == 0) ? 8'h1 : 8'h4);
      if (i > 0) chk("skip_sel", 8'(selector_mux), (i % 2 == 1) ? 8'h0 : 8'h2);
    end
    tick();
    vacio_in = 4'hF;
    #1;
    chk("skip_tail_sel", 8'(selector_mux), 8'h2);
    chk("skip_cnt", 8'({cuenta3, cuenta2, cuenta1, cuenta0}), 8'h22);

    // Backpressure
    do_reset();
    tick();
    vacio_in = 4'h0;
    tick(); #1;
    chk("bp_pop0", 8'(pop), 8'h1);
    tick(); #1;
    chk("bp_pop1", 8'(pop), 8'h2);
    tick();
    casi_lleno_out = 1'b1;
    #1;
    chk("bp_block_pop", 8'(pop), 8'h0);
    chk("bp_trail_push", 8'(push_out), 8'h1);
    chk("bp_trail_sel", 8'(selector_mux), 8'h1);
    tick(); #1;
    chk("bp_block_pop2", 8'(pop), 8'h0);
    chk("bp_no_push2", 8'(push_out), 8'h0);
    tick(); #1;
    chk("bp_block_pop3", 8'(pop), 8'h0);
    chk("bp_no_push3", 8'(push_out), 8'h0);
    tick();
    casi_lleno_out = 1'b0;
    #1;
    chk("bp_resume_pop", 8'(pop), 8'h4);
    chk("bp_resume_push", 8'(push_out), 8'h0);
    tick(); #1;
    chk("bp_next_pop", 8'(pop), 8'h8);
    chk("bp_next_sel", 8'(selector_mux), 8'h2);
    chk("bp_cnt", 8'({cuenta3, cuenta2, cuenta1, cuenta0}), 8'h15);

    // Saturation and enable drop
    do_reset();
    tick();
    vacio_in = 4'b1110;
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      chk("sat_pop", 8'(pop), 8'h1);
      chk("sat_cnt0", 8'(cuenta0), (i > 3) ? 8'h3 : 8'(i));
    end
    tick();
    enb = 1'b0;
    #1;
    chk("enb_pop", 8'(pop), 8'h0);
    chk("enb_trail_push", 8'(push_out), 8'h1);
    chk("sat_final", 8'(cuenta0), 8'h3);
    tick();
    enb = 1'b1;
    #1;
    chk("enb_estado_idle", 8'(estado), 8'h1);
    chk("enb_push_off", 8'(push_out), 8'h0);
    tick(); #1;
    chk("enb_estado_act", 8'(estado), 8'h2);
    chk("enb_pop_again", 8'(pop), 8'h1);

    // Asynchronous reset mid-stream
    do_reset();
    tick();
    vacio_in = 4'b0111;
    tick(); #1;
    chk("ar_pop", 8'(pop), 8'h8);
    tick(); #1;
    chk("ar_push_before", 8'(push_out), 8'h1);
    chk("ar_sel_before", 8'(selector_mux), 8'h3);
    reset_L = 1'b0;
    #1;
    chk("ar_push", 8'(push_out), 8'h0);
    chk("ar_sel", 8'(selector_mux), 8'h0);
    chk("ar_cnt3", 8'(cuenta3), 8'h0);
    chk("ar_estado", 8'(estado), 8'h0);
    chk("ar_pop_rst", 8'(pop), 8'h0);
    @(negedge clk);
    reset_L = 1'b1;
    tick(); #1;
    chk("ar_r1_estado", 8'(estado), 8'h1);
    chk("ar_r1_pop", 8'(pop), 8'h0);
    tick(); #1;
    chk("ar_r2_pop", 8'(pop), 8'h8);
    chk("ar_r2_push", 8'(push_out), 8'h0);
    tick(); #1;
    chk("ar_r3_push", 8'(push_out), 8'h1);
    chk("ar_r3_cnt3", 8'(cuenta3), 8'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
